// File: rtl/mips_rf_pkg.sv
// Shared defaults and types for the MIPS register file with pending scoreboard.
package mips_rf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int unsigned REG_ZERO = 0;

    typedef enum logic {
        RF_INIT,
        RF_RUN
    } rf_state_t;

endpackage

// File: rtl/rf_pend_tracker.sv
// Per-register pending bits: set by issue, cleared by writeback, set wins on collision.
module rf_pend_tracker
    import mips_rf_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_pend,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_pend
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_next;
    logic             set_ok;

    assign set_ok = set && !(ZERO_REG && (set_addr == ADDR_W'(REG_ZERO)));

    // Set is applied after clear so a new producer supersedes the writeback.
    always_comb begin
        pend_next = pend;
        if (clr)
            pend_next[clr_addr] = 1'b0;
        if (set_ok)
            pend_next[set_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            pend <= '0;
        else
            pend <= pend_next;
    end

    assign a_pend = pend[a_addr] && !(clr && (clr_addr == a_addr));
    assign b_pend = pend[b_addr] && !(clr && (clr_addr == b_addr));

endmodule

// File: rtl/mips_regfile_sb.sv
// MIPS register file: 2 async read ports, 1 write port with bypass, clear sweep, pending scoreboard.
module mips_regfile_sb
    import mips_rf_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic [ADDR_W-1:0] rs_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic              rs_pend,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rt_data,
    output logic              rt_pend,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_addr
);

    localparam int DEPTH = 1 << ADDR_W;

    rf_state_t         state, state_next;
    logic [ADDR_W-1:0] idx, idx_next;
    logic [DATA_W-1:0] rf [DEPTH];
    logic              wr_ok;
    logic              a_pend, b_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RF_INIT;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        if (state == RF_INIT) begin
            idx_next = idx + ADDR_W'(1);
            if (idx == ADDR_W'(DEPTH - 1))
                state_next = RF_RUN;
        end
    end

    assign ready = (state == RF_RUN);
    assign wr_ok = ready && we && !(ZERO_REG && (wr_addr == ADDR_W'(REG_ZERO)));

    // The array has no reset; contents hold across a reset edge and are cleared by the sweep.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == RF_INIT)
                rf[idx] <= '0;
            else if (wr_ok)
                rf[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rs_data = '0;
        if (ready && !(ZERO_REG && (rs_addr == ADDR_W'(REG_ZERO)))) begin
            if (we && (wr_addr == rs_addr))
                rs_data = wr_data;
            else
                rs_data = rf[rs_addr];
        end
    end

    always_comb begin
        rt_data = '0;
        if (ready && !(ZERO_REG && (rt_addr == ADDR_W'(REG_ZERO)))) begin
            if (we && (wr_addr == rt_addr))
                rt_data = wr_data;
            else
                rt_data = rf[rt_addr];
        end
    end

    rf_pend_tracker #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_pend (
        .clk      (clk),
        .rst      (rst),
        .set      (ready && pend_set),
        .set_addr (pend_addr),
        .clr      (ready && we),
        .clr_addr (wr_addr),
        .a_addr   (rs_addr),
        .a_pend   (a_pend),
        .b_addr   (rt_addr),
        .b_pend   (b_pend)
    );

    assign rs_pend = ready && a_pend;
    assign rt_pend = ready && b_pend;

endmodule

// File: tb/tb_mips_regfile_sb.sv
// Self-checking bench for mips_regfile_sb: vector table through a scoreboard queue plus reset/sweep sequences.
module tb_mips_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic [4:0]  rs_addr, rt_addr, wr_addr, pend_addr;
    logic [31:0] rs_data, rt_data, wr_data;
    logic        rs_pend, rt_pend, we, pend_set;

    int checks = 0;
    int errors = 0;

    mips_regfile_sb dut (
        .clk       (clk),
        .rst       (rst),
        .ready     (ready),
        .rs_addr   (rs_addr),
        .rs_data   (rs_data),
        .rs_pend   (rs_pend),
        .rt_addr   (rt_addr),
        .rt_data   (rt_data),
        .rt_pend   (rt_pend),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .pend_set  (pend_set),
        .pend_addr (pend_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ps;
        logic [4:0]  pa;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ers;
        logic [31:0] ert;
        logic        eps;
        logic        ept;
    } vec_t;

    typedef struct {
        logic [31:0] rs;
        logic [31:0] rt;
        logic        ps;
        logic        pt;
        int          id;
    } exp_t;

    vec_t tbl [16];
    exp_t exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                                input logic ps, input logic [4:0] pa,
                                input logic [4:0] ra, input logic [4:0] rb,
                                input logic [31:0] ers, input logic [31:0] ert,
                                input logic eps, input logic ept);
        vec_t v;
        v.we = w; v.wa = wa; v.wd = wd; v.ps = ps; v.pa = pa; v.ra = ra; v.rb = rb;
        v.ers = ers; v.ert = ert; v.eps = eps; v.ept = ept;
        return v;
    endfunction

    task automatic idle();
        we = 0; wr_addr = 0; wr_data = 0; pend_set = 0; pend_addr = 0;
        rs_addr = 0; rt_addr = 0;
    endtask

    // Counts edges from now until ready is seen high, bounded.
    task automatic wait_ready(output int n);
        n = 0;
        while (n < 64) begin
            @(posedge clk); #1;
            n++;
            if (ready) break;
        end
    endtask

    initial begin
        int n;
        exp_t e;

        tbl[0]  = mk(1, 8,  32'd8,        0, 0, 8,  0,  32'd8,        32'd0,        0, 0);
        tbl[1]  = mk(0, 0,  32'd0,        0, 0, 0,  8,  32'd0,        32'd8,        0, 0);
        tbl[2]  = mk(1, 0,  32'hFFFFFFFF, 0, 0, 0,  0,  32'd0,        32'd0,        0, 0);
        tbl[3]  = mk(0, 0,  32'd0,        0, 0, 0,  8,  32'd0,        32'd8,        0, 0);
        tbl[4]  = mk(0, 0,  32'd0,        1, 5, 5,  5,  32'd0,        32'd0,        0, 0);
        tbl[5]  = mk(0, 0,  32'd0,        0, 0, 5,  8,  32'd0,        32'd8,        1, 0);
        tbl[6]  = mk(1, 5,  32'd3,        0, 0, 5,  5,  32'd3,        32'd3,        0, 0);
        tbl[7]  = mk(0, 0,  32'd0,        0, 0, 5,  5,  32'd3,        32'd3,        0, 0);
        tbl[8]  = mk(1, 4,  32'd6,        1, 4, 4,  4,  32'd6,        32'd6,        0, 0);
        tbl[9]  = mk(0, 0,  32'd0,        0, 0, 4,  5,  32'd6,        32'd3,        1, 0);
        tbl[10] = mk(0, 0,  32'd0,        1, 0, 0,  4,  32'd0,        32'd6,        0, 1);
        tbl[11] = mk(0, 0,  32'd0,        0, 0, 0,  4,  32'd0,        32'd6,        0, 1);
        tbl[12] = mk(1, 31, 32'hA5A5A5A5, 0, 0, 31, 30, 32'hA5A5A5A5, 32'd0,        0, 0);
        tbl[13] = mk(0, 0,  32'd0,        0, 0, 30, 31, 32'd0,        32'hA5A5A5A5, 0, 0);
        tbl[14] = mk(1, 4,  32'd7,        1, 4, 4,  8,  32'd7,        32'd8,        0, 0);
        tbl[15] = mk(0, 0,  32'd0,        0, 0, 4,  0,  32'd7,        32'd0,        1, 0);

        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_rs_pend", {31'd0, rs_pend}, 32'd0);

        rst = 0;
        wait_ready(n);
        check("sweep1_edges", n, 32);

        // Dirty the array and a pending bit so the next reset/sweep has work to do.
        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            we = 1; wr_addr = 5'(a); wr_data = 32'hDEADBEEF;
        end
        @(negedge clk);
        we = 0; pend_set = 1; pend_addr = 9;
        @(negedge clk);
        pend_set = 0; rs_addr = 17;
        #1;
        check("preload_rs17", rs_data, 32'hDEADBEEF);

        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        wait_ready(n);
        check("sweep2_edges", n, 32);
        @(negedge clk);
        rs_addr = 17; rt_addr = 9;
        #1;
        check("cleared_rs17", rs_data, 32'd0);
        check("cleared_rt9", rt_data, 32'd0);
        check("cleared_pend9", {31'd0, rt_pend}, 32'd0);
        rs_addr = 31; rt_addr = 1;
        #1;
        check("cleared_rs31", rs_data, 32'd0);
        check("cleared_rt1", rt_data, 32'd0);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            we = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
            pend_set = tbl[i].ps; pend_addr = tbl[i].pa;
            rs_addr = tbl[i].ra; rt_addr = tbl[i].rb;
            e.rs = tbl[i].ers; e.rt = tbl[i].ert; e.ps = tbl[i].eps; e.pt = tbl[i].ept; e.id = i;
            exp_q.push_back(e);
            #1;
            e = exp_q.pop_front();
            check($sformatf("v%0d_rs_data", e.id), rs_data, e.rs);
            check($sformatf("v%0d_rt_data", e.id), rt_data, e.rt);
            check($sformatf("v%0d_rs_pend", e.id), {31'd0, rs_pend}, {31'd0, e.ps});
            check($sformatf("v%0d_rt_pend", e.id), {31'd0, rt_pend}, {31'd0, e.pt});
        end

        // Mid-sweep reset, with writes and pend_set offered during INIT.
        @(negedge clk);
        idle();
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        we = 1; wr_addr = 3; wr_data = 32'h33; pend_set = 1; pend_addr = 7;
        rs_addr = 3; rt_addr = 7;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("init_rs_forced0", rs_data, 32'd0);
        check("init_ready_low", {31'd0, ready}, 32'd0);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            check($sformatf("init2_ready_low_e%0d", k + 1), {31'd0, ready}, 32'd0);
        end
        @(negedge clk);
        idle();
        rs_addr = 3; rt_addr = 7;
        wait_ready(n);
        check("sweep3_edges", n, 32 - 12);
        @(negedge clk);
        check("init_write_dropped", rs_data, 32'd0);
        check("init_pend_ignored", {31'd0, rt_pend}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
